// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the signed iterative divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  // Width of a down-counter that must hold the number of ITER cycles.
  function automatic int unsigned cnt_w(input int unsigned width, input int unsigned spc);
    return $clog2(width / spc + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvs,
  input  logic             din,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             qbit_c
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Trial subtraction on WIDTH+1 bits so a shifted remainder never overflows the compare.
  always_comb begin
    trial      = {rem, din};
    diff       = trial - {1'b0, dvs};
    qbit_c     = (trial >= {1'b0, dvs});
    rem_next_c = qbit_c ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/signed_divider.sv
// Iterative restoring divider with runtime signed/unsigned mode, SPC quotient bits per
// cycle, valid/ready on both sides and divide-by-zero / signed-overflow flags.
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration when |x| < |y|.
module signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned NITER = WIDTH / SPC;
  localparam int unsigned CW    = cnt_w(WIDTH, SPC);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic             sgn_r;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] chain [SPC+1];
  logic [SPC-1:0]   qbits;

  // Operand magnitudes; MIN maps to 2^(WIDTH-1), which is exact as an unsigned value.
  always_comb begin
    x_mag = (sgn_r && xr[WIDTH-1]) ? -xr : xr;
    y_mag = (sgn_r && yr[WIDTH-1]) ? -yr : yr;
  end

  assign chain[0] = rem;

  // SPC chained steps consume dividend bits MSB-first from dq.
  for (genvar i = 0; i < SPC; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem       (chain[i]),
      .dvs       (dvs),
      .din       (dq[WIDTH-1-i]),
      .rem_next_c(chain[i+1]),
      .qbit_c    (qbits[SPC-1-i])
    );
  end

  // Control FSM and datapath registers; dq holds the dividend and fills with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      sgn_r     <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xr       <= x;
            yr       <= y;
            sgn_r    <= sgn;
            in_ready <= 1'b0;
            if (y == '0) begin
              q         <= '1;
              r         <= x;
              dbz       <= 1'b1;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (sgn && (x == MIN) && (y == '1)) begin
              q         <= MIN;
              r         <= '0;
              dbz       <= 1'b0;
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= PREP;
            end
          end
        end
        PREP: begin
          q_neg <= sgn_r & (xr[WIDTH-1] ^ yr[WIDTH-1]);
          r_neg <= sgn_r & xr[WIDTH-1];
          dvs   <= y_mag;
          rem   <= '0;
          dq    <= x_mag;
          cnt   <= CW'(NITER);
          state <= ITER;
`ifdef DIV_EARLY_OUT_EN
          if (x_mag < y_mag) begin
            dq    <= '0;
            rem   <= x_mag;
            state <= FIX;
          end
`endif
        end
        ITER: begin
          rem <= chain[SPC];
          dq  <= WIDTH'({dq, qbits});
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          q         <= q_neg ? -dq : dq;
          r         <= r_neg ? -rem : rem;
          dbz       <= 1'b0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: random and directed requests, reference model
// from plain integer division, decoupled monitor with random backpressure.
module tb_signed_divider;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SPC   = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, sgn, out_valid, out_ready, dbz, ovf;
  logic [7:0] x, y, q, r;

  logic       in_valid2, in_ready2, sgn2, out_valid2, out_ready2, dbz2, ovf2;
  logic [7:0] x2, y2, q2, r2;

  signed_divider #(.WIDTH(WIDTH), .SPC(SPC)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r),
    .dbz(dbz), .ovf(ovf)
  );

  signed_divider #(.WIDTH(WIDTH), .SPC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .sgn(sgn2),
    .x(x2), .y(y2), .out_valid(out_valid2), .out_ready(out_ready2), .q(q2), .r(r2),
    .dbz(dbz2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   bp_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Reference: integer division truncates toward zero and % takes the dividend's sign.
  // Latency counts rising edges after the accept edge; error results appear right away.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input int spc);
    exp_t e;
    int   ai, bi, aa, ab;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1; e.lat = 0;
    end else begin
      if (s) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'(a);
        bi = int'(b);
      end
      e.q   = 8'(ai / bi);
      e.r   = 8'(ai % bi);
      e.lat = 8 / spc + 2;
      aa    = (ai < 0) ? -ai : ai;
      ab    = (bi < 0) ? -bi : bi;
`ifdef DIV_EARLY_OUT_EN
      if (aa < ab) e.lat = 2;
`else
      if (aa < 0 || ab < 0) e.lat = -1;
`endif
    end
    return e;
  endfunction

  // Issue one request on the main DUT; junk in_valid while busy must be ignored.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 300) begin
      in_valid = 1'($urandom % 2);
      x = 8'($urandom);
      y = 8'($urandom);
      sgn = 1'($urandom);
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      timeout("send_wait_ready");
      return;
    end
    in_valid = 1'b1;
    x = a;
    y = b;
    sgn = s;
    @(posedge clk);
    #1;
    e = model(a, b, s, SPC);
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each new result, checks hold stability under backpressure.
  initial begin : monitor
    exp_t       e;
    bit         prev;
    int         hold, wt;
    logic [7:0] hq, hr;
    prev = 0; hold = 0; wt = 0; hq = '0; hr = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0;
        wt = 0;
        continue;
      end
      if (out_valid) begin
        wt = 0;
        if (!prev) begin
          if (sbq.size() == 0) begin
            timeout("unexpected_result");
          end else begin
            e = sbq.pop_front();
            chk("q", q, e.q);
            chk("r", r, e.r);
            chk("dbz", dbz, e.dbz);
            chk("ovf", ovf, e.ovf);
            chk("latency", cyc - e.acc, e.lat);
            chk("in_ready_busy", in_ready, 0);
          end
          hq = q;
          hr = r;
          hold = bp_req ? 5 : 0;
          bp_req = 0;
        end else begin
          chk("hold_q", q, hq);
          chk("hold_r", r, hr);
          chk("hold_in_ready", in_ready, 0);
        end
        prev = 1;
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'(($urandom % 4) != 0);
        end
      end else begin
        prev = 0;
        out_ready = 1'($urandom % 2);
        if (sbq.size() > 0) begin
          wt++;
          if (wt > 100) begin
            timeout("result_wait");
            void'(sbq.pop_front());
            wt = 0;
          end
        end
      end
    end
  end

  // Directed request on the SPC=2 instance, checked inline.
  task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   t, acc;
    t = 0;
    while (!in_ready2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_valid2 = 1'b1;
    x2 = a;
    y2 = b;
    sgn2 = s;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid2 = 1'b0;
    e = model(a, b, s, 2);
    @(negedge clk);
    t = 0;
    while (!out_valid2 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid2) begin
      timeout("spc2_result_wait");
      return;
    end
    chk("spc2_q", q2, e.q);
    chk("spc2_r", r2, e.r);
    chk("spc2_dbz", dbz2, e.dbz);
    chk("spc2_ovf", ovf2, e.ovf);
    chk("spc2_latency", cyc - acc, e.lat);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout("drain");
  endtask

  initial begin : driver
    logic [7:0] a, b;
    logic       s;
    rst_n = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; sgn = 1'b0;
    in_valid2 = 1'b0; x2 = '0; y2 = '0; sgn2 = 1'b0; out_ready2 = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    bp_req = 1;
    send(8'd11, 8'd3, 1'b0);
    send(8'd249, 8'd2, 1'b1);
    send(8'd248, 8'd254, 1'b0);
    send(8'd10, 8'd0, 1'b0);
    send(8'd55, 8'd11, 1'b0);
    send(8'h80, 8'hFF, 1'b1);
    send(8'h80, 8'hFF, 1'b0);
    send(8'd3, 8'd11, 1'b0);
    send(8'd33, 8'd11, 1'b0);
    send(8'd0, 8'd5, 1'b1);
    send(8'h80, 8'd2, 1'b1);
    send(8'hF9, 8'd0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      case ($urandom % 8)
        0: b = 8'd0;
        1: begin a = 8'h80; b = 8'hFF; s = 1'b1; end
        2: a = 8'($urandom % 4);
        default: ;
      endcase
      repeat ($urandom % 3) @(negedge clk);
      send(a, b, s);
    end
    drain();

    // Reset in the middle of an iteration discards the operation.
    @(negedge clk);
    in_valid = 1'b1; x = 8'd100; y = 8'd7; sgn = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_q", q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd100, 8'd7, 1'b0);
    drain();

    run2(8'd11, 8'd3, 1'b0);
    run2(8'd249, 8'd2, 1'b1);
    run2(8'd200, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) run2(8'($urandom), 8'($urandom | 1), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
